run_controller: RTL

//   Run-control sequencer for the manquehuito 8-bit single-cycle core. Owns the core

---
 rtl/run_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run-control sequencer for the manquehuito core.
// Gates core updates, handles RUN/HALT/STEP/CLR and breakpoints.
module run_controller #(
    parameter int CNT_W  = 16,
    parameter int STEP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_i,
    input  logic [STEP_W-1:0] cmd_arg_i,
    input  logic [7:0]        pc_i,
    input  logic              bp_en_i,
    input  logic [7:0]        bp_addr_i,
    output logic              core_en_o,
    output logic [1:0]        state_o,
    output logic              halted_o,
    output logic              bp_hit_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [1:0] {
        S_HALTED = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2
    } state_t;

    localparam logic [1:0] C_RUN  = 2'd0;
    localparam logic [1:0] C_HALT = 2'd1;
    localparam logic [1:0] C_STEP = 2'd2;
    localparam logic [1:0] C_CLR  = 2'd3;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step_left;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                r_skip_bp;
    logic                w_skip_nxt;
    logic                r_bp_hit;
    logic                w_bp_hit_nxt;
    logic [CNT_W-1:0]    r_retired;
    logic                w_accept;
    logic                w_bp_match;
    logic                w_core_en;
    logic [STEP_W-1:0]   w_step_arg;

    // Handshake, breakpoint compare and core enable
    always_comb begin
        cmd_ready_o = !((r_state == S_STEP) &&
                        ((cmd_i == C_RUN) || (cmd_i == C_STEP)));
        w_accept    = cmd_valid_i && cmd_ready_o;
        w_bp_match  = bp_en_i && (pc_i == bp_addr_i) && !r_skip_bp;
        w_core_en   = ((r_state == S_RUN) || (r_state == S_STEP)) &&
                      !w_bp_match;
        w_step_arg  = (cmd_arg_i == '0) ? STEP_W'(1) : cmd_arg_i;
    end

    // Next-state logic; a breakpoint halt wins over a same-cycle clear
    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step_left;
        w_skip_nxt   = r_skip_bp && !w_core_en;
        w_bp_hit_nxt = r_bp_hit;
        if (w_accept && (cmd_i != C_HALT)) begin
            w_bp_hit_nxt = 1'b0;
        end
        unique case (r_state)
            S_HALTED: begin
                if (w_accept && (cmd_i == C_RUN)) begin
                    w_state_nxt = S_RUN;
                    w_skip_nxt  = 1'b1;
                end else if (w_accept && (cmd_i == C_STEP)) begin
                    w_state_nxt = S_STEP;
                    w_step_nxt  = w_step_arg;
                    w_skip_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_bp_match) begin
                    w_state_nxt  = S_HALTED;
                    w_bp_hit_nxt = 1'b1;
                end else if (w_accept && (cmd_i == C_HALT)) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_STEP: begin
                if (w_bp_match) begin
                    w_state_nxt  = S_HALTED;
                    w_bp_hit_nxt = 1'b1;
                    w_step_nxt   = '0;
                end else begin
                    w_step_nxt = r_step_left - STEP_W'(1);
                    if (r_step_left <= STEP_W'(1)) begin
                        w_state_nxt = S_HALTED;
                        w_step_nxt  = '0;
                    end
                    if (w_accept && (cmd_i == C_HALT)) begin
                        w_state_nxt = S_HALTED;
                        w_step_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HALTED;
                w_step_nxt  = '0;
            end
        endcase
    end

    // State, step counter, skip flag and sticky breakpoint flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_HALTED;
            r_step_left <= '0;
            r_skip_bp   <= 1'b0;
            r_bp_hit    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_left <= w_step_nxt;
            r_skip_bp   <= w_skip_nxt;
            r_bp_hit    <= w_bp_hit_nxt;
        end
    end

    // Saturating retired-instruction counter; CLR beats increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_retired <= '0;
        end else if (w_accept && (cmd_i == C_CLR)) begin
            r_retired <= '0;
        end else if (w_core_en && (r_retired != {CNT_W{1'b1}})) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign core_en_o = w_core_en;
    assign state_o   = r_state;
    assign halted_o  = (r_state == S_HALTED);
    assign bp_hit_o  = r_bp_hit;
    assign retired_o = r_retired;

endmodule
